// File: rtl/sram_access_ctrl.sv
// Initiator-side sequencer for the compiled SRAM array: turns single-beat
// read/write requests into a setup / access / hold pin sequence plus a response.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WRITE_CYCLES = 2,
  parameter int unsigned SENSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LD = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_we, w_we_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_we, w_rsp_we_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt;
  logic              r_wen, w_wen_nxt;
  logic              r_sen, w_sen_nxt;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_wen       <= 1'b0;
      r_sen       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_we    <= w_rsp_we_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_wen       <= w_wen_nxt;
      r_sen       <= w_sen_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition fires
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_we_nxt    = r_rsp_we;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_busy_nxt      = r_busy;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_wen_nxt       = r_wen;
    w_sen_nxt       = r_sen;

    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt     = SETUP;
          w_cnt_nxt       = SETUP_LD;
          w_we_nxt        = req_we;
          w_req_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_addr_nxt      = req_addr;
          // Reads leave din at its previous value to avoid needless pin toggling
          if (req_we) w_din_nxt = req_wdata;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = r_we ? WRITE_LD : SENSE_LD;
          w_wen_nxt   = r_we;
          w_sen_nxt   = !r_we;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ACCESS: begin
        if (w_cnt_zero) begin
          w_state_nxt     = HOLD;
          w_cnt_nxt       = HOLD_LD;
          w_wen_nxt       = 1'b0;
          w_sen_nxt       = 1'b0;
          w_rsp_we_nxt    = r_we;
          w_rsp_rdata_nxt = r_we ? '0 : sram_dout;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = '0;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_wen_nxt       = 1'b0;
        w_sen_nxt       = 1'b0;
      end
    endcase
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_we        = r_rsp_we;
  assign rsp_rdata     = r_rsp_rdata;
  assign busy          = r_busy;
  assign sram_addr     = r_addr;
  assign sram_din      = r_din;
  assign sram_write_en = r_wen;
  assign sram_sense_en = r_sen;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: default-parameter instance plus a swept-timing
// instance, each driving a behavioural array model.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_we, a_busy, a_wen, a_sen;
  logic [7:0]  a_rsp_rdata, a_din, a_dout;
  logic [11:0] a_addr;
  logic        b_req_ready, b_rsp_valid, b_rsp_we, b_busy, b_wen, b_sen;
  logic [7:0]  b_rsp_rdata, b_din, b_dout;
  logic [11:0] b_addr;

  logic [7:0]  mem_a [0:4095];
  logic [7:0]  mem_b [0:4095];
  logic [2:0]  b_sc;

  always #5 clk = ~clk;

  sram_access_ctrl u_dut_a (
    .clk(clk), .reset(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_we(a_rsp_we),
    .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .sram_addr(a_addr), .sram_din(a_din), .sram_write_en(a_wen),
    .sram_sense_en(a_sen), .sram_dout(a_dout)
  );

  sram_access_ctrl #(
    .SETUP_CYCLES(3), .WRITE_CYCLES(1), .SENSE_CYCLES(4), .HOLD_CYCLES(2)
  ) u_dut_b (
    .clk(clk), .reset(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_we(b_rsp_we),
    .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .sram_addr(b_addr), .sram_din(b_din), .sram_write_en(b_wen),
    .sram_sense_en(b_sen), .sram_dout(b_dout)
  );

  // Array models; the swept one returns 0xFF until the 4th sense cycle
  always @(posedge clk) begin
    if (a_wen) mem_a[a_addr] <= a_din;
    if (b_wen) mem_b[b_addr] <= b_din;
    b_sc <= b_sen ? b_sc + 3'd1 : 3'd0;
  end
  assign a_dout = mem_a[a_addr];
  assign b_dout = (b_sen && b_sc == 3'd3) ? mem_b[b_addr] : 8'hFF;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_we, cur_busy, cur_wen, cur_sen;
  logic [7:0]  cur_rsp_rdata;
  logic [11:0] cur_addr;
  assign cur_req_ready = sel ? b_req_ready : a_req_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_rsp_we    = sel ? b_rsp_we    : a_rsp_we;
  assign cur_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign cur_busy      = sel ? b_busy      : a_busy;
  assign cur_wen       = sel ? b_wen       : a_wen;
  assign cur_sen       = sel ? b_sen       : a_sen;
  assign cur_addr      = sel ? b_addr      : a_addr;

  int          cyc = 0;
  logic        trk_on;
  logic [11:0] exp_addr;
  int mon_cyc = 0, mon_we = 0, mon_se = 0, mon_first = 0, mon_addr_bad = 0, mon_rv = 0;
  int mon_overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-transaction pin monitor, sampled mid-cycle
  always @(negedge clk) begin
    if ((a_wen && a_sen) || (b_wen && b_sen)) mon_overlap <= mon_overlap + 1;
    if (!trk_on) begin
      mon_cyc <= 0; mon_we <= 0; mon_se <= 0; mon_first <= 0;
      mon_addr_bad <= 0; mon_rv <= 0;
    end else begin
      mon_cyc <= mon_cyc + 1;
      if (cur_wen) mon_we <= mon_we + 1;
      if (cur_sen) mon_se <= mon_se + 1;
      if (mon_first == 0 && (cur_wen || cur_sen)) mon_first <= mon_cyc + 1;
      if (cur_addr != exp_addr) mon_addr_bad <= mon_addr_bad + 1;
      if (cur_rsp_valid) mon_rv <= mon_rv + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on the selected instance with rsp_ready high; returns latency and response
  task automatic do_txn(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                        output int lat, output logic rwe, output logic [7:0] rdata);
    int n;
    @(negedge clk);
    n = 0;
    while (!cur_req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", 32'(cur_req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    exp_addr  = addr;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    trk_on    = 1'b1;
    lat = 0;
    while (!cur_rsp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    rwe   = cur_rsp_we;
    rdata = cur_rsp_rdata;
    @(posedge clk); #1;
    trk_on = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        gap_chk;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, n, prev_acc, bad_v, bad_d, bad_r;
    logic        rwe;
    logic [7:0]  rdata;

    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; trk_on = 1'b0; exp_addr = '0;
    prev_acc = 0;

    //              we    addr     wdata  exp    gap
    vecs[0]  = '{1'b1, 12'h000, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 12'h000, 8'h00, 8'hA5, 1'b1};
    vecs[2]  = '{1'b1, 12'hFFF, 8'h3C, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 12'h001, 8'hC3, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 12'hFFF, 8'h00, 8'h3C, 1'b1};
    vecs[5]  = '{1'b0, 12'h001, 8'h00, 8'hC3, 1'b1};
    vecs[6]  = '{1'b1, 12'h010, 8'h55, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 12'h010, 8'h00, 8'h55, 1'b1};
    vecs[8]  = '{1'b1, 12'h010, 8'hAA, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 12'h010, 8'h00, 8'hAA, 1'b1};
    vecs[10] = '{1'b1, 12'h010, 8'h55, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 12'h010, 8'h00, 8'h55, 1'b1};
    vecs[12] = '{1'b1, 12'h010, 8'hAA, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 12'h010, 8'h00, 8'hAA, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_busy",      32'(a_busy),      32'd0);
    check("rst_enables",   32'({a_wen, a_sen}), 32'd0);
    check("rst_addr_din",  32'({a_addr, a_din}), 32'd0);
    check("rst_rsp_data",  32'({a_rsp_we, a_rsp_rdata}), 32'd0);
    check("rst_b_ready",   32'(b_req_ready), 32'd1);
    rst = 1'b0;

    // Directed write/read table on the default-timing instance
    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rwe, rdata);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_rsp_we", i), 32'(rwe), 32'(vecs[i].we));
      check($sformatf("v%0d_rsp_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_first_enable_cycle", i), 32'(mon_first), 32'd2);
      check($sformatf("v%0d_write_en_cycles", i), 32'(mon_we), vecs[i].we ? 32'd2 : 32'd0);
      check($sformatf("v%0d_sense_en_cycles", i), 32'(mon_se), vecs[i].we ? 32'd0 : 32'd2);
      check($sformatf("v%0d_addr_stable", i), 32'(mon_addr_bad), 32'd0);
      if (vecs[i].gap_chk) check($sformatf("v%0d_accept_gap", i), 32'(acc_cyc - prev_acc), 32'd6);
      prev_acc = acc_cyc;
    end

    // Response backpressure with a pending request
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFF; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
    check("bp_latency", 32'(n), 32'd4);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h100; req_wdata = 8'h77;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!a_rsp_valid || !a_busy) bad_v++;
      if (a_rsp_rdata != 8'h3C || a_rsp_we != 1'b0 || a_addr != 12'hFFF) bad_d++;
      if (a_req_ready) bad_r++;
    end
    check("bp_rsp_valid_held", 32'(bad_v), 32'd0);
    check("bp_rsp_data_held",  32'(bad_d), 32'd0);
    check("bp_req_ready_low",  32'(bad_r), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake_idle",  32'({a_busy, a_req_ready, a_rsp_valid}), 32'b010);
    @(posedge clk); #1;
    check("bp_pending_accept",  32'({a_busy, a_req_ready}), 32'b10);
    req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
    check("bp_wr_latency", 32'(n), 32'd4);
    check("bp_wr_rsp", 32'({a_rsp_we, a_rsp_rdata}), 32'h100);
    @(posedge clk); #1;
    do_txn(1'b0, 12'h100, 8'h00, lat, rwe, rdata);
    check("bp_wr_readback", 32'(rdata), 32'h77);

    // Reset during the first sense cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h000; exp_addr = 12'h000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    trk_on = 1'b1;
    n = 0;
    while (!a_sen && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_sense_seen", 32'(a_sen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_enables", 32'({a_wen, a_sen}), 32'd0);
    check("rst_mid_ready_idle", 32'({a_req_ready, a_busy}), 32'b10);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_rsp", 32'(mon_rv), 32'd0);
    check("rst_mid_still_idle", 32'({a_req_ready, a_busy}), 32'b10);
    trk_on = 1'b0;

    // Swept timing instance
    sel = 1'b1;
    do_txn(1'b1, 12'h123, 8'h5A, lat, rwe, rdata);
    check("sw_wr_latency", 32'(lat), 32'd6);
    check("sw_wr_write_en_cycles", 32'(mon_we), 32'd1);
    check("sw_wr_first_enable", 32'(mon_first), 32'd4);
    check("sw_wr_rsp", 32'({rwe, rdata}), 32'h100);
    do_txn(1'b0, 12'h123, 8'h00, lat, rwe, rdata);
    check("sw_rd_latency", 32'(lat), 32'd9);
    check("sw_rd_sense_cycles", 32'(mon_se), 32'd4);
    check("sw_rd_first_enable", 32'(mon_first), 32'd4);
    check("sw_rd_rdata", 32'(rdata), 32'h5A);
    check("sw_rd_rsp_we", 32'(rwe), 32'd0);
    sel = 1'b0;

    check("enable_overlap", 32'(mon_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
